// File: rtl/fetch_step_pkg.sv
// Shared types and defaults for the instruction-fetch stage and its neighbours.
// The pipeline NOP encoding lives here for the decode stage.
package fetch_step_pkg;
    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PS_DEF = 32'h0000_0000;
    localparam word_t PS_STEP_DEF  = 32'd4;
    localparam word_t NOP_INSTR    = 32'h0000_0013;
endpackage

// File: rtl/fetch_step_if.sv
// Fetch-stage bundle: I-cache request/response, decode hand-off and execute redirect.
// master = fetch stage, slave = the surrounding pipeline.
interface fetch_step_if;
    import fetch_step_pkg::*;

    logic  bellek_gecerli_i;
    word_t bellek_deger_i;
    logic  bellek_istek_o;
    word_t bellek_ps_o;
    logic  coz_bos_i;
    word_t coz_buyruk_o;
    logic  coz_buyruk_gecerli_o;
    word_t coz_ps_o;
    word_t yurut_ps_i;
    logic  yurut_ps_gecerli_i;
    logic  yurut_atladi_i;

    modport master (
        input  bellek_gecerli_i, bellek_deger_i, coz_bos_i,
               yurut_ps_i, yurut_ps_gecerli_i, yurut_atladi_i,
        output bellek_istek_o, bellek_ps_o, coz_buyruk_o,
               coz_buyruk_gecerli_o, coz_ps_o
    );

    modport slave (
        output bellek_gecerli_i, bellek_deger_i, coz_bos_i,
               yurut_ps_i, yurut_ps_gecerli_i, yurut_atladi_i,
        input  bellek_istek_o, bellek_ps_o, coz_buyruk_o,
               coz_buyruk_gecerli_o, coz_ps_o
    );
endinterface

// File: rtl/fetch_redirect_ctl.sv
// Pending-redirect register and next-PC selection for the fetch stage.
// Combinational next-PC; a redirect seen while decode is busy is parked until decode frees up.
module fetch_redirect_ctl
    import fetch_step_pkg::*;
#(
    parameter word_t PS_STEP = PS_STEP_DEF
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  coz_bos_i,
    input  logic  bellek_gecerli_i,
    input  logic  yurut_ps_gecerli_i,
    input  logic  yurut_atladi_i,
    input  word_t yurut_ps_i,
    input  word_t ps_i,
    output word_t ps_d_o,
    output word_t ps_inc_o,
    output logic  accept_o
);
    logic  live_redir;
    logic  take_redir;
    logic  pend_q, pend_d;
    word_t pend_ps_q, pend_ps_d;

    always_comb begin
        live_redir = yurut_ps_gecerli_i & yurut_atladi_i;
        take_redir = coz_bos_i & (live_redir | pend_q);
        ps_inc_o   = ps_i + PS_STEP;
        accept_o   = coz_bos_i & bellek_gecerli_i & ~take_redir;
        ps_d_o     = ps_i;
        pend_d     = pend_q;
        pend_ps_d  = pend_ps_q;
        // A live redirect is newer than a parked one, so it wins.
        if (take_redir) begin
            ps_d_o = live_redir ? yurut_ps_i : pend_ps_q;
            pend_d = 1'b0;
        end else if (!coz_bos_i && live_redir) begin
            pend_d    = 1'b1;
            pend_ps_d = yurut_ps_i;
        end else if (accept_o) begin
            ps_d_o = ps_inc_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_q    <= 1'b0;
            pend_ps_q <= '0;
        end else begin
            pend_q    <= pend_d;
            pend_ps_q <= pend_ps_d;
        end
    end
endmodule

// File: rtl/fetch_step.sv
// Instruction-fetch stage: owns the PC, requests words from the I-cache, hands them to decode.
// 1-cycle latency cache word -> decode; decode not empty freezes PC and drops the request.
module fetch_step
    import fetch_step_pkg::*;
#(
    parameter word_t RESET_PS = RESET_PS_DEF,
    parameter word_t PS_STEP  = PS_STEP_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_step_if.master bus
);
    word_t ps_q, ps_d, ps_inc;
    word_t buyruk_q, coz_ps_q;
    logic  gecerli_q;
    logic  accept;

    fetch_redirect_ctl #(.PS_STEP(PS_STEP)) u_redirect (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .coz_bos_i          (bus.coz_bos_i),
        .bellek_gecerli_i   (bus.bellek_gecerli_i),
        .yurut_ps_gecerli_i (bus.yurut_ps_gecerli_i),
        .yurut_atladi_i     (bus.yurut_atladi_i),
        .yurut_ps_i         (bus.yurut_ps_i),
        .ps_i               (ps_q),
        .ps_d_o             (ps_d),
        .ps_inc_o           (ps_inc),
        .accept_o           (accept)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ps_q      <= RESET_PS;
            buyruk_q  <= '0;
            coz_ps_q  <= '0;
            gecerli_q <= 1'b0;
        end else begin
            ps_q      <= ps_d;
            gecerli_q <= accept;
            if (accept) begin
                buyruk_q <= bus.bellek_deger_i;
                coz_ps_q <= ps_inc;
            end
        end
    end

    assign bus.bellek_istek_o       = bus.coz_bos_i & rst_i;
    assign bus.bellek_ps_o          = ps_q;
    assign bus.coz_buyruk_o         = buyruk_q;
    assign bus.coz_buyruk_gecerli_o = gecerli_q;
    assign bus.coz_ps_o             = coz_ps_q;
endmodule

// File: tb/tb_fetch_step.sv
// Bench for fetch_step: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a rule-level model of the fetch stage.
module tb_fetch_step;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    fetch_step_if bus ();

    fetch_step dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Model state: what the stage must present after the last edge.
    logic [31:0] m_ps, m_pend_ps, m_buy, m_cozps;
    logic        m_pend, m_vld;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ps = 32'h0; m_pend = 1'b0; m_pend_ps = 32'h0;
            m_buy = 32'h0; m_cozps = 32'h0; m_vld = 1'b0;
        end else begin
            logic live;
            live = bus.yurut_ps_gecerli_i && bus.yurut_atladi_i;
            if (bus.coz_bos_i && (live || m_pend)) begin
                m_ps   = live ? bus.yurut_ps_i : m_pend_ps;
                m_pend = 1'b0;
                m_vld  = 1'b0;
            end else if (!bus.coz_bos_i && live) begin
                m_pend    = 1'b1;
                m_pend_ps = bus.yurut_ps_i;
                m_vld     = 1'b0;
            end else if (bus.coz_bos_i && bus.bellek_gecerli_i) begin
                m_buy   = bus.bellek_deger_i;
                m_ps    = m_ps + 32'd4;
                m_cozps = m_ps;
                m_vld   = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_istek",   {31'b0, bus.bellek_istek_o}, {31'b0, bus.coz_bos_i & rst_n});
            chk("model_ps",      bus.bellek_ps_o, m_ps);
            chk("model_vld",     {31'b0, bus.coz_buyruk_gecerli_o}, {31'b0, m_vld});
            chk("model_buyruk",  bus.coz_buyruk_o, m_buy);
            chk("model_coz_ps",  bus.coz_ps_o, m_cozps);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic bos, input logic bg, input logic [31:0] dg,
                         input logic yg, input logic at, input logic [31:0] yp);
        bus.coz_bos_i          = bos;
        bus.bellek_gecerli_i   = bg;
        bus.bellek_deger_i     = dg;
        bus.yurut_ps_gecerli_i = yg;
        bus.yurut_atladi_i     = at;
        bus.yurut_ps_i         = yp;
    endtask

    initial begin
        logic [31:0] tgt;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc();
        cmp_en = 1'b1;
        cyc();
        chk("rst_ps",     bus.bellek_ps_o, 32'h0);
        chk("rst_vld",    {31'b0, bus.coz_buyruk_gecerli_o}, 32'h0);
        chk("rst_coz_ps", bus.coz_ps_o, 32'h0);
        chk("rst_buyruk", bus.coz_buyruk_o, 32'h0);
        rst_n = 1'b1;

        drive(1'b1, 1'b1, 32'h00B8FF11, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("fetch_istek",  {31'b0, bus.bellek_istek_o}, 32'h1);
        chk("fetch_ps",     bus.bellek_ps_o, 32'h4);
        chk("fetch_buyruk", bus.coz_buyruk_o, 32'h00B8FF11);
        chk("fetch_vld",    {31'b0, bus.coz_buyruk_gecerli_o}, 32'h1);
        chk("fetch_coz_ps", bus.coz_ps_o, 32'h4);

        bus.coz_bos_i = 1'b0;
        cyc();
        chk("stall_istek",  {31'b0, bus.bellek_istek_o}, 32'h0);
        chk("stall_ps",     bus.bellek_ps_o, 32'h4);
        chk("stall_buyruk", bus.coz_buyruk_o, 32'h00B8FF11);
        chk("stall_vld",    {31'b0, bus.coz_buyruk_gecerli_o}, 32'h0);
        chk("stall_coz_ps", bus.coz_ps_o, 32'h4);

        drive(1'b1, 1'b1, 32'h00B8FF13, 1'b1, 1'b0, 32'hFFB8FF13);
        cyc();
        chk("nt_ps",     bus.bellek_ps_o, 32'h8);
        chk("nt_coz_ps", bus.coz_ps_o, 32'h8);
        chk("nt_buyruk", bus.coz_buyruk_o, 32'h00B8FF13);
        chk("nt_vld",    {31'b0, bus.coz_buyruk_gecerli_o}, 32'h1);

        tgt = 32'h0000_0202;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, tgt);
        cyc();
        chk("pend_ps_hold", bus.bellek_ps_o, 32'h8);
        chk("pend_vld",     {31'b0, bus.coz_buyruk_gecerli_o}, 32'h0);
        drive(1'b1, 1'b1, 32'hDEAD0001, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("pend_apply_ps", bus.bellek_ps_o, tgt);
        chk("pend_apply_vld", {31'b0, bus.coz_buyruk_gecerli_o}, 32'h0);
        drive(1'b1, 1'b1, 32'hCAFE0002, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("pend_next_coz_ps", bus.coz_ps_o, 32'h0000_0206);
        chk("pend_next_buyruk", bus.coz_buyruk_o, 32'hCAFE0002);

        drive(1'b1, 1'b1, 32'h1111_2222, 1'b1, 1'b1, 32'h100);
        cyc();
        chk("tk_ps",     bus.bellek_ps_o, 32'h100);
        chk("tk_vld",    {31'b0, bus.coz_buyruk_gecerli_o}, 32'h0);
        chk("tk_buyruk", bus.coz_buyruk_o, 32'hCAFE0002);

        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        cyc();
        drive(1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("wrap_ps",     bus.bellek_ps_o, 32'h0);
        chk("wrap_coz_ps", bus.coz_ps_o, 32'h0);

        drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0000_0A00);
        cyc();
        drive(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0000_0B00);
        cyc();
        chk("live_beats_pend", bus.bellek_ps_o, 32'h0000_0B00);
        drive(1'b1, 1'b1, 32'h0000_7777, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("pend_cleared", bus.bellek_ps_o, 32'h0000_0B04);

        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0333);
        cyc();
        chk("miss_ps",    bus.bellek_ps_o, 32'h0000_0B04);
        chk("miss_istek", {31'b0, bus.bellek_istek_o}, 32'h1);

        drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0000_0500);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("arst_ps",     bus.bellek_ps_o, 32'h0);
        chk("arst_vld",    {31'b0, bus.coz_buyruk_gecerli_o}, 32'h0);
        chk("arst_buyruk", bus.coz_buyruk_o, 32'h0);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_4444, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("arst_pend_dropped", bus.bellek_ps_o, 32'h4);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] yp;
            yp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), yp);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            cyc();
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
